// File: rtl/kmeans_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : kmeans_regfile                                                |
// | Purpose  : Register file and host front-end of the k-means accelerator.  |
// |            Holds GO/STATUS, eight centroid registers, the point-RAM      |
// |            address window and an indirect RAM_DATA port into point RAM.  |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            host : h_sel h_en h_write h_addr h_wdata -> h_rdata h_ready   |
// |                   h_err                                                  |
// |            core : reg_num reg_write core_wdata -> core_rdata, go,         |
// |                   first_ram_addr, last_ram_addr; go_signal, interupt in  |
// |            ram  : ram_addr ram_wdata ram_rdata, active-low strobes       |
// |            irq  : host interrupt (= STATUS.done)                         |
// | Config   : KMEANS_RF_RAM_AUTOINC_EN - RAM_ADDR post-increments after     |
// |            every successful RAM_DATA access                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module kmeans_regfile #(
  parameter int DATA_W = 91,
  parameter int REG_AW = 4,
  parameter int RAM_AW = 9,
  parameter int RAM_W  = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              h_sel,
  input  logic              h_en,
  input  logic              h_write,
  input  logic [REG_AW-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_ready,
  output logic              h_err,
  input  logic [REG_AW-1:0] reg_num,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              go,
  input  logic              go_signal,
  input  logic              interupt,
  output logic [RAM_AW-1:0] first_ram_addr,
  output logic [RAM_AW-1:0] last_ram_addr,
  output logic              irq,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_W-1:0]  ram_wdata,
  input  logic [RAM_W-1:0]  ram_rdata,
  output logic              ram_wr_en_n,
  output logic              ram_output_en_n,
  output logic              ram_chip_select_n
);

  localparam logic [REG_AW-1:0] c_reg_status   = REG_AW'(0);
  localparam logic [REG_AW-1:0] c_reg_go       = REG_AW'(1);
  localparam logic [REG_AW-1:0] c_reg_cent_lo  = REG_AW'(2);
  localparam logic [REG_AW-1:0] c_reg_cent_hi  = REG_AW'(9);
  localparam logic [REG_AW-1:0] c_reg_ram_addr = REG_AW'(10);
  localparam logic [REG_AW-1:0] c_reg_ram_data = REG_AW'(11);
  localparam logic [REG_AW-1:0] c_reg_first    = REG_AW'(12);
  localparam logic [REG_AW-1:0] c_reg_last     = REG_AW'(13);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_REQ = 2'd1,
    ST_RD_CAP = 2'd2,
    ST_WR_REQ = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_done, r_go, r_err, r_int_d;
  logic [DATA_W-1:0]   r_cent [8];
  logic [RAM_AW-1:0]   r_ram_addr, r_first, r_last;
  logic [RAM_W-1:0]    r_ram_wdata, r_cap;
  logic                r_cs_n, r_oe_n, r_we_n;

  logic                w_acc, w_hwr, w_ramdata, w_ram_blk, w_ram_start, w_rsvd;
  logic                w_int_rise, w_core_wr, w_host_cent_wr, w_collide;
  logic [2:0]          w_hidx, w_cidx;

  function automatic logic is_cent(input logic [REG_AW-1:0] a);
    return (a >= c_reg_cent_lo) && (a <= c_reg_cent_hi);
  endfunction

  // Plain register read mux shared by host and core; RAM_DATA and the
  // reserved numbers read as zero here.
  function automatic logic [DATA_W-1:0] read_reg(input logic [REG_AW-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    case (a)
      c_reg_status:   v[2:0] = {r_err, r_go, r_done};
      c_reg_go:       v[0] = r_go;
      c_reg_ram_addr: v[RAM_AW-1:0] = r_ram_addr;
      c_reg_first:    v[RAM_AW-1:0] = r_first;
      c_reg_last:     v[RAM_AW-1:0] = r_last;
      default:        if (is_cent(a)) v = r_cent[3'(a - c_reg_cent_lo)];
    endcase
    return v;
  endfunction

  // A new host access is only accepted while the RAM path is idle; during
  // RAM_DATA wait states the host is holding the same request.
  assign w_acc       = h_sel & h_en & (r_state == ST_IDLE);
  assign w_hwr       = w_acc & h_write;
  assign w_ramdata   = (h_addr == c_reg_ram_data);
  assign w_ram_blk   = go_signal | r_go;
  assign w_ram_start = w_acc & w_ramdata & ~w_ram_blk;
  assign w_rsvd      = (h_addr > c_reg_last);
  assign w_int_rise  = interupt & ~r_int_d;

  assign w_hidx         = 3'(h_addr - c_reg_cent_lo);
  assign w_cidx         = 3'(reg_num - c_reg_cent_lo);
  assign w_core_wr      = reg_write & is_cent(reg_num);
  assign w_host_cent_wr = w_hwr & is_cent(h_addr);
  assign w_collide      = w_core_wr & w_host_cent_wr & (reg_num == h_addr);

  always_comb begin
    h_ready = 1'b0;
    h_err   = 1'b0;
    h_rdata = '0;
    case (r_state)
      ST_RD_CAP: begin
        h_ready = 1'b1;
        h_rdata = DATA_W'(r_cap);
      end
      ST_WR_REQ: h_ready = 1'b1;
      ST_IDLE: begin
        if (w_acc && !w_ram_start) begin
          h_ready = 1'b1;
          h_err   = w_rsvd | w_ramdata;
          if (!h_write && !w_rsvd && !w_ramdata) h_rdata = read_reg(h_addr);
        end
      end
      default: ;
    endcase
  end

  assign core_rdata        = read_reg(reg_num);
  assign go                = r_go;
  assign irq               = r_done;
  assign first_ram_addr    = r_first;
  assign last_ram_addr     = r_last;
  assign ram_addr          = r_ram_addr;
  assign ram_wdata         = r_ram_wdata;
  assign ram_wr_en_n       = r_we_n;
  assign ram_output_en_n   = r_oe_n;
  assign ram_chip_select_n = r_cs_n;

  // Control/status and register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_d    <= 1'b0;
      r_done     <= 1'b0;
      r_go       <= 1'b0;
      r_err      <= 1'b0;
      r_ram_addr <= '0;
      r_first    <= '0;
      r_last     <= '0;
      for (int i = 0; i < 8; i++) r_cent[i] <= '0;
    end else begin
      r_int_d <= interupt;

      if (w_int_rise) r_done <= 1'b1;
      else if (w_hwr && h_addr == c_reg_status && h_wdata[0]) r_done <= 1'b0;

      // Completion beats a same-cycle host GO write.
      if (w_int_rise) r_go <= 1'b0;
      else if (w_hwr && h_addr == c_reg_go && h_wdata[0]) r_go <= 1'b1;

      if (w_collide || (w_acc && w_ramdata && w_ram_blk)) r_err <= 1'b1;
      else if (w_hwr && h_addr == c_reg_status && h_wdata[2]) r_err <= 1'b0;

      if (w_core_wr) r_cent[w_cidx] <= core_wdata;
      if (w_host_cent_wr && !w_collide) r_cent[w_hidx] <= h_wdata;

      if (w_hwr && h_addr == c_reg_first) r_first <= h_wdata[RAM_AW-1:0];
      if (w_hwr && h_addr == c_reg_last)  r_last  <= h_wdata[RAM_AW-1:0];

      if (w_hwr && h_addr == c_reg_ram_addr) r_ram_addr <= h_wdata[RAM_AW-1:0];
`ifdef KMEANS_RF_RAM_AUTOINC_EN
      // Advance on the completing edge so the address is stable under the strobes.
      else if (r_state == ST_RD_CAP || r_state == ST_WR_REQ)
        r_ram_addr <= r_ram_addr + RAM_AW'(1);
`endif
    end
  end

  // RAM_DATA sequencer with registered, glitch-free strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cs_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_ram_wdata <= '0;
      r_cap       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ram_start) begin
            r_cs_n <= 1'b0;
            if (h_write) begin
              r_we_n      <= 1'b0;
              r_ram_wdata <= h_wdata[RAM_W-1:0];
              r_state     <= ST_WR_REQ;
            end else begin
              r_oe_n  <= 1'b0;
              r_state <= ST_RD_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          r_cap   <= ram_rdata;
          r_cs_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_state <= ST_RD_CAP;
        end
        ST_RD_CAP: r_state <= ST_IDLE;
        ST_WR_REQ: begin
          r_cs_n  <= 1'b1;
          r_we_n  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kmeans_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_kmeans_regfile                                             |
// | Purpose  : Self-checking bench for kmeans_regfile: vector table,         |
// |            directed corner sequences and a randomized run against a      |
// |            behavioural register/RAM model.                               |
// | Config   : honours KMEANS_RF_RAM_AUTOINC_EN in its model                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_kmeans_regfile;
  localparam int DW = 91, RAW = 4, MAW = 9, MW = 50;
`ifdef KMEANS_RF_RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic h_sel = 0, h_en = 0, h_write = 0;
  logic [RAW-1:0] h_addr = '0, reg_num = '0;
  logic [DW-1:0] h_wdata = '0, core_wdata = '0;
  logic reg_write = 0, go_signal = 0, interupt = 0;
  logic [DW-1:0] h_rdata, core_rdata;
  logic h_ready, h_err, go, irq, ram_wr_en_n, ram_output_en_n, ram_chip_select_n;
  logic [MAW-1:0] first_ram_addr, last_ram_addr, ram_addr;
  logic [MW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  kmeans_regfile dut (
    .clk(clk), .rst_n(rst_n), .h_sel(h_sel), .h_en(h_en), .h_write(h_write),
    .h_addr(h_addr), .h_wdata(h_wdata), .h_rdata(h_rdata), .h_ready(h_ready),
    .h_err(h_err), .reg_num(reg_num), .reg_write(reg_write), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .go(go), .go_signal(go_signal), .interupt(interupt),
    .first_ram_addr(first_ram_addr), .last_ram_addr(last_ram_addr), .irq(irq),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_wr_en_n(ram_wr_en_n), .ram_output_en_n(ram_output_en_n),
    .ram_chip_select_n(ram_chip_select_n)
  );

  // Point RAM device: async read, write on strobes, plus bench fill/poke.
  logic [MW-1:0] tbram [512];
  logic fill_req = 0, poke_req = 0;
  int fill_seed = 0;
  logic [MAW-1:0] poke_addr = '0;
  logic [MW-1:0] poke_data = '0;
  int wr_pulses = 0, rd_pulses = 0;
  logic [MAW-1:0] last_wr_addr = '0;
  logic [MW-1:0] last_wr_data = '0;

  function automatic logic [MW-1:0] ram_init(input int i, input int s);
    logic [63:0] x;
    x = (64'(i) * 64'h9E37_79B9_7F4A_7C15) ^ 64'(s);
    return x[MW-1:0];
  endfunction

  assign ram_rdata = tbram[ram_addr];

  always @(posedge clk) begin
    if (fill_req) for (int i = 0; i < 512; i++) tbram[i] <= ram_init(i, fill_seed);
    else if (poke_req) tbram[poke_addr] <= poke_data;
    if (!ram_chip_select_n && !ram_wr_en_n) begin
      tbram[ram_addr] <= ram_wdata;
      wr_pulses++;
      last_wr_addr = ram_addr;
      last_wr_data = ram_wdata;
    end
    if (!ram_chip_select_n && !ram_output_en_n) rd_pulses++;
  end

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [RAW-1:0] a, input logic [DW-1:0] d,
                      output logic [DW-1:0] rd, output logic er, output int lat);
    @(negedge clk);
    h_sel = 1; h_en = 1; h_write = wr; h_addr = a; h_wdata = d;
    lat = 0;
    #1;
    while (!h_ready && lat < 6) begin
      @(negedge clk); #1; lat++;
    end
    rd = h_rdata; er = h_err;
    if (!h_ready) begin
      n_checks++; n_fail++;
      $display("FAIL xfer_timeout: addr %0d got no h_ready expected h_ready", a);
    end
    @(posedge clk); #1;
    h_sel = 0; h_en = 0; h_write = 0;
  endtask

  task automatic core_wr(input logic [RAW-1:0] r, input logic [DW-1:0] d);
    @(negedge clk); reg_num = r; core_wdata = d; reg_write = 1;
    @(negedge clk); reg_write = 0;
  endtask

  task automatic pulse_int();
    @(negedge clk); interupt = 1;
    @(negedge clk); interupt = 0;
  endtask

  function automatic logic [DW-1:0] rand_dw();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  typedef struct {
    logic           wr;
    logic [RAW-1:0] addr;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  exp_rd;
    logic           exp_err;
    int             exp_lat;
  } vec_t;
  vec_t vt [14];

  // Behavioural model for the randomized run.
  logic [DW-1:0] m_cent [8];
  logic m_done, m_go, m_err;
  logic [MAW-1:0] m_raddr, m_first, m_last;
  logic [MW-1:0] m_ram [512];

  task automatic model_host(input logic wr, input logic [RAW-1:0] a, input logic [DW-1:0] d,
                            input logic gs, output logic [DW-1:0] erd, output logic eer,
                            output int elat);
    erd = '0; eer = 0; elat = 0;
    if (a >= 14) eer = 1;
    else if (a == 11) begin
      if (gs || m_go) begin
        eer = 1; m_err = 1;
      end else begin
        if (wr) begin m_ram[m_raddr] = d[MW-1:0]; elat = 1; end
        else begin erd = DW'(m_ram[m_raddr]); elat = 2; end
        if (AUTOINC) m_raddr = m_raddr + 9'd1;
      end
    end else if (wr) begin
      case (a)
        0: begin if (d[0]) m_done = 0; if (d[2]) m_err = 0; end
        1: if (d[0]) m_go = 1;
        10: m_raddr = d[MAW-1:0];
        12: m_first = d[MAW-1:0];
        13: m_last = d[MAW-1:0];
        default: m_cent[int'(a) - 2] = d;
      endcase
    end else begin
      case (a)
        0: erd = DW'({m_err, m_go, m_done});
        1: erd = DW'(m_go);
        10: erd = DW'(m_raddr);
        12: erd = DW'(m_first);
        13: erd = DW'(m_last);
        default: erd = m_cent[int'(a) - 2];
      endcase
    end
  endtask

  logic [DW-1:0] rd, erd, hv, cv;
  logic er, eer;
  int lat, elat, w0, r0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b0, 4'd2,  91'h0,       91'h0,     1'b0, 0};
    vt[1]  = '{1'b1, 4'd4,  91'h1234,    91'h0,     1'b0, 0};
    vt[2]  = '{1'b0, 4'd4,  91'h0,       91'h1234,  1'b0, 0};
    vt[3]  = '{1'b1, 4'd12, 91'hAB,      91'h0,     1'b0, 0};
    vt[4]  = '{1'b1, 4'd13, 91'h7FFFFFF, 91'h0,     1'b0, 0};
    vt[5]  = '{1'b0, 4'd12, 91'h0,       91'hAB,    1'b0, 0};
    vt[6]  = '{1'b0, 4'd13, 91'h0,       91'h1FF,   1'b0, 0};
    vt[7]  = '{1'b0, 4'd15, 91'h0,       91'h0,     1'b1, 0};
    vt[8]  = '{1'b1, 4'd14, {DW{1'b1}},  91'h0,     1'b1, 0};
    vt[9]  = '{1'b0, 4'd14, 91'h0,       91'h0,     1'b1, 0};
    vt[10] = '{1'b1, 4'd10, 91'h1FF,     91'h0,     1'b0, 0};
    vt[11] = '{1'b0, 4'd10, 91'h0,       91'h1FF,   1'b0, 0};
    vt[12] = '{1'b0, 4'd0,  91'h0,       91'h0,     1'b0, 0};
    vt[13] = '{1'b0, 4'd1,  91'h0,       91'h0,     1'b0, 0};

    fill_seed = 7; fill_req = 1;
    @(posedge clk); #1 fill_req = 0;
    reg_num = 4'd2;
    #1;
    chk("rst_go", go, 0);              chk("rst_irq", irq, 0);
    chk("rst_h_ready", h_ready, 0);    chk("rst_h_err", h_err, 0);
    chk("rst_h_rdata", h_rdata, 0);    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);chk("rst_first", first_ram_addr, 0);
    chk("rst_last", last_ram_addr, 0); chk("rst_core_rdata", core_rdata, 0);
    chk("rst_strobes", {ram_wr_en_n, ram_output_en_n, ram_chip_select_n}, 3'b111);
    @(negedge clk) rst_n = 1;

    // Vector table
    for (int i = 0; i < 14; i++) begin
      xfer(vt[i].wr, vt[i].addr, vt[i].wdata, rd, er, lat);
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), er, vt[i].exp_err);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
    end
    chk("first_port", first_ram_addr, 9'hAB);
    chk("last_port", last_ram_addr, 9'h1FF);

    // Core port
    reg_num = 4'd4; #1;
    chk("core_rdata_cent3", core_rdata, 91'h1234);
    core_wr(4'd4, 91'hABC);
    xfer(0, 4'd4, 0, rd, er, lat);  chk("host_sees_core_wr", rd, 91'hABC);
    core_wr(4'd0, {DW{1'b1}});
    xfer(0, 4'd0, 0, rd, er, lat);  chk("core_wr_status_ignored", rd, 0);

    // GO / interrupt
    xfer(1, 4'd1, 91'h1, rd, er, lat);
    chk("go_set", go, 1);
    pulse_int(); #1;
    chk("go_cleared_by_int", go, 0);  chk("irq_set", irq, 1);
    xfer(0, 4'd0, 0, rd, er, lat);  chk("status_done", rd, 91'b001);
    xfer(1, 4'd0, 91'h1, rd, er, lat); chk("irq_cleared", irq, 0);
    xfer(1, 4'd1, 91'h0, rd, er, lat); chk("go_bit0_zero_ignored", go, 0);

    // RAM write at top address (RAM_ADDR is 511 from the table)
    w0 = wr_pulses;
    xfer(1, 4'd11, 91'h55, rd, er, lat);
    chk("ramwr_lat", lat, 1);           chk("ramwr_err", er, 0);
    chk("ramwr_pulses", wr_pulses - w0, 1);
    chk("ramwr_addr", last_wr_addr, 9'h1FF);
    chk("ramwr_data", last_wr_data, 50'h55);
    xfer(0, 4'd10, 0, rd, er, lat);
    chk("ram_addr_after_wr", rd, AUTOINC ? 91'h0 : 91'h1FF);

    // RAM read
    xfer(1, 4'd10, 91'd37, rd, er, lat);
    @(negedge clk); poke_req = 1; poke_addr = 9'd37; poke_data = 50'h3FF;
    @(posedge clk); #1 poke_req = 0;
    r0 = rd_pulses;
    xfer(0, 4'd11, 0, rd, er, lat);
    chk("ramrd_lat", lat, 2);  chk("ramrd_data", rd, 91'h3FF);
    chk("ramrd_err", er, 0);   chk("ramrd_pulses", rd_pulses - r0, 1);

    // RAM access blocked by go_signal, then by go
    w0 = wr_pulses; r0 = rd_pulses;
    go_signal = 1;
    xfer(0, 4'd11, 0, rd, er, lat);
    go_signal = 0;
    chk("blk_gs_err", er, 1);  chk("blk_gs_lat", lat, 0);
    chk("blk_gs_no_strobe", rd_pulses - r0, 0);
    xfer(0, 4'd0, 0, rd, er, lat);  chk("blk_gs_status_err", rd, 91'b100);
    xfer(1, 4'd0, 91'h4, rd, er, lat);
    xfer(1, 4'd1, 91'h1, rd, er, lat);
    xfer(1, 4'd11, 91'h77, rd, er, lat);
    chk("blk_go_err", er, 1);  chk("blk_go_lat", lat, 0);
    chk("blk_go_no_strobe", wr_pulses - w0, 0);
    pulse_int();
    xfer(1, 4'd0, 91'h5, rd, er, lat);
    xfer(0, 4'd0, 0, rd, er, lat);  chk("status_all_clear", rd, 0);

    // Same-cycle host and core write to CENT_8
    hv = 91'h111; cv = 91'h222;
    @(negedge clk);
    h_sel = 1; h_en = 1; h_write = 1; h_addr = 4'd9; h_wdata = hv;
    reg_num = 4'd9; core_wdata = cv; reg_write = 1;
    #1 chk("coll_ready", h_ready, 1);
    @(posedge clk); #1;
    h_sel = 0; h_en = 0; h_write = 0; reg_write = 0;
    xfer(0, 4'd9, 0, rd, er, lat);  chk("coll_core_wins", rd, cv);
    xfer(0, 4'd0, 0, rd, er, lat);  chk("coll_status_err", rd, 91'b100);

    // GO write coinciding with interrupt rising edge
    @(negedge clk);
    h_sel = 1; h_en = 1; h_write = 1; h_addr = 4'd1; h_wdata = 91'h1; interupt = 1;
    @(posedge clk); #1;
    h_sel = 0; h_en = 0; h_write = 0;
    chk("go_int_same_cycle", go, 0);  chk("go_int_irq", irq, 1);
    @(negedge clk) interupt = 0;

    // Asynchronous reset in the middle of a RAM read
    xfer(1, 4'd10, 91'd5, rd, er, lat);
    @(negedge clk);
    h_sel = 1; h_en = 1; h_write = 0; h_addr = 4'd11;
    @(posedge clk); #2;
    chk("midrd_cs_low", ram_chip_select_n, 0);
    #1 rst_n = 0;
    #1;
    chk("midrd_rst_cs", ram_chip_select_n, 1);
    chk("midrd_rst_oe", ram_output_en_n, 1);
    chk("midrd_rst_ready", h_ready, 0);
    chk("midrd_rst_irq", irq, 0);
    chk("midrd_rst_wdata", ram_wdata, 0);
    h_sel = 0; h_en = 0;

    // Randomized run against the model
    fill_seed = 1234; fill_req = 1;
    @(posedge clk); #1 fill_req = 0;
    for (int i = 0; i < 512; i++) m_ram[i] = ram_init(i, 1234);
    for (int i = 0; i < 8; i++) m_cent[i] = '0;
    m_done = 0; m_go = 0; m_err = 0; m_raddr = '0; m_first = '0; m_last = '0;
    @(negedge clk) rst_n = 1;

    for (int it = 0; it < 400; it++) begin
      int kind, r;
      logic wr, gs;
      logic [DW-1:0] d;
      kind = int'($urandom_range(0, 9));
      d = rand_dw();
      if (kind == 0) begin
        pulse_int();
        m_done = 1; m_go = 0;
      end else if (kind == 1) begin
        r = int'($urandom_range(0, 15));
        core_wr(4'(r), d);
        if (r >= 2 && r <= 9) m_cent[r - 2] = d;
      end else begin
        wr = 1'($urandom_range(0, 1));
        r = int'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) r = 11;
        if (r == 10) d = DW'($urandom_range(500, 511));
        gs = ($urandom_range(0, 7) == 0);
        model_host(wr, 4'(r), d, gs, erd, eer, elat);
        go_signal = gs;
        xfer(wr, 4'(r), d, rd, er, lat);
        go_signal = 0;
        if (!wr && (r != 11 || !eer)) chk($sformatf("rnd%0d_rd_r%0d", it, r), rd, erd);
        chk($sformatf("rnd%0d_err_r%0d", it, r), er, eer);
        chk($sformatf("rnd%0d_lat_r%0d", it, r), lat, elat);
      end
      @(negedge clk);
      reg_num = 4'($urandom_range(2, 9));
      #1;
      chk($sformatf("rnd%0d_go", it), go, m_go);
      chk($sformatf("rnd%0d_irq", it), irq, m_done);
      chk($sformatf("rnd%0d_core_rdata", it), core_rdata, m_cent[int'(reg_num) - 2]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kmeans_regfile.md
# kmeans_regfile

Register file and host front-end for the k-means accelerator, responding to the controller's register interface (`reg_num`/`reg_write`). It also gives the host bus an indirect path into the point RAM. The block holds GO, status, eight centroid registers and the RAM address window, and services host accesses. It also latches the controller's interrupt into a host-visible done flag and `irq`, and arbitrates point-RAM access between host and controller.

## Interface
Parameters:
- `DATA_W`, 91: centroid word width (7 coordinates × 13 bits); also the host data width.
- `REG_AW`, 4: register number width.
- `RAM_AW`, 9: point RAM address width.
- `RAM_W`, 50: point RAM word width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: asynchronous, active-low. Clock is `clk`.
- `h_sel`  in  1  host select.
- `h_en`  in  1  host access phase.
- `h_write`  in  1  1 = write.
- `h_addr`  in  REG_AW  register number.
- `h_wdata`  in  DATA_W  host write data.
- `h_rdata`  out  DATA_W  host read data; valid when `h_ready`=1.
- `h_ready`  out  1  access completes this cycle.
- `h_err`  out  1  error response, qualified by `h_ready`.
- `reg_num`  in  REG_AW  controller register select.
- `reg_write`  in  1  controller write strobe.
- `core_wdata`  in  DATA_W  controller write data.
- `core_rdata`  out  DATA_W  contents of register `reg_num`; combinational.
- `go`  out  1  level start request to the controller.
- `go_signal`  in  1  controller owns the RAM.
- `interupt`  in  1  controller completion flag.
- `first_ram_addr`, `last_ram_addr`  out  RAM_AW  point window.
- `irq`  out  1  host interrupt.
- `ram_addr`  out  RAM_AW  host-path RAM address.
- `ram_wdata`  out  RAM_W  host-path RAM write data.
- `ram_rdata`  in  RAM_W  RAM read data.
- `ram_wr_en_n`, `ram_output_en_n`, `ram_chip_select_n`  out  1 each  active-low RAM strobes.

## Operation
Register map:
- 0: STATUS.
  - bit0 `done`: set on rising edge of `interupt`; host write of 1 to bit0 clears it.
  - bit1 `busy` (= `go`): read-only.
  - bit2 `err`: sticky; write 1 to clear.
- 1: GO. Host write with bit0=1 sets `go`. `go` clears on rising edge of `interupt`. A write with bit0=0 is ignored.
- 2–9: CENT_1..CENT_8. Full `DATA_W` width; host and core read/write.
- 10: RAM_ADDR. `RAM_AW` bits.
- 11: RAM_DATA. Indirect RAM access; see below.
- 12: FIRST_RAM_ADDR. Drives `first_ram_addr`.
- 13: LAST_RAM_ADDR. Drives `last_ram_addr`.
- 14–15: reserved. Read returns 0 with `h_err`=1; writes are ignored with `h_err`=1.

Core port:
- `reg_write`=1 with `reg_num` in 2..9 writes `core_wdata` at the next edge.
- Core writes to any other `reg_num` are ignored.
- If host and core write the same register in the same cycle, the core wins, the host write is dropped, and STATUS.err is set.

`irq` = STATUS.done.

RAM_DATA state machine (IDLE, RD_REQ, RD_CAP, WR_REQ):
- IDLE → RD_REQ on host read of reg 11. Drive `ram_chip_select_n`=0 and `ram_output_en_n`=0 with `ram_addr`=RAM_ADDR.
- RD_REQ → RD_CAP. Capture `ram_rdata`, zero-extended into `h_rdata`, assert `h_ready`; then → IDLE.
- IDLE → WR_REQ on host write of reg 11. Drive CSB=0, WEB=0, `ram_wdata`=`h_wdata[RAM_W-1:0]`, assert `h_ready`; then → IDLE.
- Any RAM_DATA access while `go_signal`=1 or `go`=1 completes immediately with `h_ready`=1 and `h_err`=1. No RAM strobes are driven and STATUS.err is set.

## Timing
- Register (non-RAM) accesses take zero wait states: `h_ready`=1 in the cycle where `h_sel`&`h_en` are true. Writes take effect at that cycle's closing edge.
- RAM read: `h_ready` rises 2 cycles after the access cycle. RAM write: `h_ready` rises 1 cycle after.
- `h_ready`=0 in RD_REQ. Host must hold `h_addr`/`h_wdata` stable until `h_ready`.
- Reset values: all registers 0.
  - Outputs `go`, `irq`, `h_ready`, `h_err` = 0.
  - `h_rdata`, `ram_addr`, `ram_wdata`, `first_ram_addr`, `last_ram_addr` = 0.
  - `core_rdata` = CENT reg contents = 0.
  - `ram_*_n` = 1.
  - State machine returns to IDLE.
- Reset mid-RAM access aborts the access: strobes return high asynchronously.
- Host GO write in the same cycle as the `interupt` rising edge: the clear wins, so `go`=0.

## Configuration
- `KMEANS_RF_RAM_AUTOINC_EN`:
  - Defined: RAM_ADDR increments by 1 after each successful RAM_DATA access, wrapping from 2^RAM_AW−1 to 0.
  - Undefined: RAM_ADDR changes only on host writes to reg 10.

## Test plan
- Reset: all outputs at the values listed under Timing; host read of reg 2 returns 0 with `h_ready`=1.
- Host write CENT_3=0x1234 (reg 4), then `reg_num`=4 → `core_rdata`=0x1234. Core write reg 4 = 0xABC → host read of reg 4 returns 0xABC.
- Write GO=1 → `go`=1 next cycle. Pulse `interupt` → `go`=0, `irq`=1, STATUS=0b001. Write STATUS=1 → `irq`=0.
- RAM_ADDR=511, write RAM_DATA=0x55 → one WEB low pulse at address 511, `h_ready` after 1 cycle. With the macro defined, RAM_ADDR reads back 0; without it, 511.
- Read RAM_DATA with `ram_rdata`=0x3FF → `h_ready` after 2 cycles, `h_rdata`=0x3FF. Same read with `go_signal`=1 → immediate `h_err`=1, no strobes, STATUS.err=1.
- Same-cycle host and core write to reg 9 → core value kept, STATUS.err=1. Read of reg 15 → `h_err`=1, `h_rdata`=0.
